irrigation_scheduler: RTL and testbench
=======================================

# irrigation_scheduler

Sequences the irrigation actuators once the irrigation prerequisite check grants permission. Takes the registered permit and a dripper/sprinkler mode select and runs a timed cycle: debounce the permit, open exactly one valve for a bounded time, then enforce a rest period before the next cycle. Sits between the prerequisite check and the dripper/sprinkler valve drivers, and is the only block allowed to drive those valves.

## Interface
- SETTLE_TICKS, 2: ticks the permit must stay high before a valve opens (≥1).
- MAX_RUN_TICKS, 10: maximum ticks a valve stays open per cycle (≥1).
- REST_TICKS, 5: ticks both valves stay closed after any run (≥1).
- CNT_W, 8: tick counter width; each *_TICKS value must be < 2^CNT_W.

- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; forces IDLE and clears the counter.
- tick  in  1  single-cycle time-base enable pulse, e.g. 1 Hz.
- irrigation  in  1  permit from the prerequisite check (sensors OK, water OK, earth dry).
- sprinkler_mode  in  1  1 = sprinkler, 0 = dripper; sampled only on entry to RUN.
- dripper_valve  out  1  dripper valve open.
- sprinkler_valve  out  1  sprinkler valve open.
- busy  out  1  state ≠ IDLE.
- resting  out  1  state == REST.
- run_timeout  out  1  one-cycle pulse when RUN ends by reaching MAX_RUN_TICKS.

## Operation
- States: IDLE, SETTLE, RUN, REST; 2-bit encoding. Counter cnt is CNT_W bits.
- cnt clears to 0 on every state change. Within a state, cnt increments on cycles where tick = 1.
- "Expires(N)" means tick = 1 and cnt == N−1, so a state lasts exactly N ticks.
- IDLE:
  - irrigation = 1 → SETTLE.
- SETTLE:
  - irrigation = 0 → IDLE. This takes priority over expiry.
  - Expires(SETTLE_TICKS) → RUN, and the sel register latches sprinkler_mode on the same edge.
- RUN:
  - sprinkler_valve = sel; dripper_valve = ~sel.
  - irrigation = 0 → REST, with no timeout pulse. This takes priority over expiry.
  - Expires(MAX_RUN_TICKS) → REST, and run_timeout = 1 for the next cycle only.
  - Changes to sprinkler_mode while in RUN are ignored.
- REST:
  - Valves are closed.
  - Expires(REST_TICKS) → IDLE. irrigation is ignored until then.
  - If irrigation is still high on reaching IDLE, the next edge goes to SETTLE (a new debounce).
- Valves are decoded from the registered state and sel only. dripper_valve and sprinkler_valve are never both 1.
- Reset values: state IDLE, cnt 0, sel 0, every output 0.
- Reset asserted mid-RUN: both valves read 0 in the cycle after the reset edge. No REST period is applied after reset.
- Unused state encoding → IDLE on the next edge.

## Timing
- Permit-to-valve latency: 1 edge (IDLE→SETTLE), plus SETTLE_TICKS ticks, plus the expiry edge. The valve is high in the first cycle with state == RUN.
- Permit drop to valve closed: the valve is low in the cycle after the first edge that samples irrigation = 0.
- A tick pulse coinciding with a state-change edge does not count toward the new state.
- run_timeout is registered, is high for exactly one cycle, and coincides with the first REST cycle.
- busy and resting are valid in the same cycle as the state register.

## Test plan
- **Reset:** assert reset for 2 cycles with irrigation = 1 → all outputs 0, state IDLE.
- **Nominal dripper cycle** (defaults, irrigation = 1, mode = 0, tick every 4 clocks):
  - dripper_valve rises after exactly 2 ticks in SETTLE.
  - It stays high for 10 ticks.
  - run_timeout pulses once.
  - Then 5 ticks of REST.
  - Then SETTLE again.
  - sprinkler_valve stays 0 throughout.
- **Permit glitch:** irrigation high for 1 tick, then low in SETTLE → returns to IDLE, no valve ever opens, cnt restarts at 0 on the next permit.
- **Early stop:** mode = 1; drop irrigation at tick 3 of RUN in the same cycle as tick → sprinkler_valve low the next cycle, REST entered, run_timeout stays 0, REST lasts 5 ticks even though irrigation rises again immediately.
- **Mode change mid-run:** toggle sprinkler_mode 0→1 during RUN → dripper_valve stays on, sprinkler_valve stays 0. The next cycle opens sprinkler_valve.
- **Reset mid-run:** assert reset during RUN → valves 0 next cycle, busy = 0. With irrigation = 1 after release, a full SETTLE is required before a valve reopens.

Source files
------------

// File: rtl/irrigation_scheduler.sv
// Irrigation actuator sequencer: debounces the permit, opens exactly one valve
// (dripper or sprinkler) for a bounded number of ticks, then enforces a rest period.
module irrigation_scheduler #(
  parameter int SETTLE_TICKS  = 2,
  parameter int MAX_RUN_TICKS = 10,
  parameter int REST_TICKS    = 5,
  parameter int CNT_W         = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic irrigation,
  input  logic sprinkler_mode,
  output logic dripper_valve,
  output logic sprinkler_valve,
  output logic busy,
  output logic resting,
  output logic run_timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2,
    S_REST   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(MAX_RUN_TICKS - 1);
  localparam logic [CNT_W-1:0] REST_LAST   = CNT_W'(REST_TICKS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sel;
  logic             r_run_timeout;
  logic             w_timeout;
  logic             w_latch_sel;

  always_comb begin
    w_next      = r_state;
    w_timeout   = 1'b0;
    w_latch_sel = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (irrigation) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        // A dropped permit wins over an expiry on the same edge.
        if (!irrigation) begin
          w_next = S_IDLE;
        end else if (tick && (r_cnt == SETTLE_LAST)) begin
          w_next      = S_RUN;
          w_latch_sel = 1'b1;
        end
      end
      S_RUN: begin
        if (!irrigation) begin
          w_next = S_REST;
        end else if (tick && (r_cnt == RUN_LAST)) begin
          w_next    = S_REST;
          w_timeout = 1'b1;
        end
      end
      S_REST: begin
        if (tick && (r_cnt == REST_LAST)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_sel         <= 1'b0;
      r_run_timeout <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_run_timeout <= w_timeout;
      // A tick on a state-change edge is not credited to the new state.
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (tick) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_latch_sel) r_sel <= sprinkler_mode;
    end
  end

  assign dripper_valve   = (r_state == S_RUN) && !r_sel;
  assign sprinkler_valve = (r_state == S_RUN) &&  r_sel;
  assign busy            = (r_state != S_IDLE);
  assign resting         = (r_state == S_REST);
  assign run_timeout     = r_run_timeout;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed and randomized bench for irrigation_scheduler against a countdown
// reference model of the irrigation cycle.
module tb_irrigation_scheduler;
  localparam int SETTLE_TICKS  = 2;
  localparam int MAX_RUN_TICKS = 10;
  localparam int REST_TICKS    = 5;
  localparam int CNT_W         = 8;

  localparam int PH_IDLE   = 0;
  localparam int PH_SETTLE = 1;
  localparam int PH_RUN    = 2;
  localparam int PH_REST   = 3;

  logic clock          = 1'b0;
  logic reset          = 1'b1;
  logic tick           = 1'b0;
  logic irrigation     = 1'b1;
  logic sprinkler_mode = 1'b0;
  logic dripper_valve, sprinkler_valve, busy, resting, run_timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: phase plus ticks remaining before the phase ends.
  int   m_ph   = PH_IDLE;
  int   m_left = 0;
  logic m_sel  = 1'b0;
  logic m_to   = 1'b0;

  int n_drip_ticks = 0;
  int n_spr_high   = 0;
  int n_to         = 0;
  int clk_n        = 0;

  always #5 clock = ~clock;

  irrigation_scheduler #(
    .SETTLE_TICKS (SETTLE_TICKS),
    .MAX_RUN_TICKS(MAX_RUN_TICKS),
    .REST_TICKS   (REST_TICKS),
    .CNT_W        (CNT_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .tick           (tick),
    .irrigation     (irrigation),
    .sprinkler_mode (sprinkler_mode),
    .dripper_valve  (dripper_valve),
    .sprinkler_valve(sprinkler_valve),
    .busy           (busy),
    .resting        (resting),
    .run_timeout    (run_timeout)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic irr, input logic md, input logic tk);
    m_to = 1'b0;
    if (r) begin
      m_ph = PH_IDLE; m_left = 0; m_sel = 1'b0;
    end else begin
      case (m_ph)
        PH_IDLE:
          if (irr) begin m_ph = PH_SETTLE; m_left = SETTLE_TICKS; end
        PH_SETTLE:
          if (!irr) m_ph = PH_IDLE;
          else if (tk) begin
            m_left--;
            if (m_left == 0) begin m_ph = PH_RUN; m_left = MAX_RUN_TICKS; m_sel = md; end
          end
        PH_RUN:
          if (!irr) begin m_ph = PH_REST; m_left = REST_TICKS; end
          else if (tk) begin
            m_left--;
            if (m_left == 0) begin m_ph = PH_REST; m_left = REST_TICKS; m_to = 1'b1; end
          end
        default:
          if (tk) begin
            m_left--;
            if (m_left == 0) m_ph = PH_IDLE;
          end
      endcase
    end
  endtask

  // Check outputs against the model, then apply inputs for the next edge.
  task automatic step(input logic r, input logic irr, input logic md, input logic tk);
    @(negedge clock);
    clk_n++;
    chk("dripper_valve",   dripper_valve,   (m_ph == PH_RUN) && !m_sel);
    chk("sprinkler_valve", sprinkler_valve, (m_ph == PH_RUN) &&  m_sel);
    chk("busy",            busy,            m_ph != PH_IDLE);
    chk("resting",         resting,         m_ph == PH_REST);
    chk("run_timeout",     run_timeout,     m_to);
    chk("valve_exclusive", dripper_valve && sprinkler_valve, 1'b0);
    if (run_timeout) n_to++;
    if (sprinkler_valve) n_spr_high++;
    reset = r; irrigation = irr; sprinkler_mode = md; tick = tk;
    if (dripper_valve && tk) n_drip_ticks++;
    model_edge(r, irr, md, tk);
  endtask

  function automatic logic tk4();
    return (clk_n % 4) == 3;
  endfunction

  initial begin
    bit seen_rest;
    logic r_i, irr_i, md_i;

    // Reset held for two cycles with the permit already high.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);

    // Nominal dripper cycle, tick every 4 clocks, until SETTLE re-entered after REST.
    n_drip_ticks = 0; n_spr_high = 0; n_to = 0; seen_rest = 0;
    step(1'b0, 1'b1, 1'b0, tk4());
    for (int k = 0; k < 400; k++) begin
      if (m_ph == PH_REST) seen_rest = 1;
      if (seen_rest && m_ph == PH_SETTLE) break;
      step(1'b0, 1'b1, 1'b0, tk4());
    end
    chk_int("nominal_reached_settle", int'(seen_rest && m_ph == PH_SETTLE), 1);
    chk_int("nominal_drip_ticks", n_drip_ticks, MAX_RUN_TICKS);
    chk_int("nominal_timeouts", n_to, 1);
    chk_int("nominal_sprinkler_high", n_spr_high, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // Permit glitch: one tick in SETTLE, then drop; later a fresh permit.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_int("glitch_still_settling", int'(busy && !dripper_valve && !sprinkler_valve), 1);

    // Early stop in sprinkler mode: drop the permit on the third RUN tick.
    for (int k = 0; k < 200 && m_ph != PH_RUN; k++) step(1'b0, 1'b1, 1'b1, tk4());
    for (int k = 0; k < 200 && m_left > MAX_RUN_TICKS - 2; k++) step(1'b0, 1'b1, 1'b1, tk4());
    for (int k = 0; k < 8 && !tk4(); k++) step(1'b0, 1'b1, 1'b1, 1'b0);
    n_to = 0;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 30; k++) step(1'b0, 1'b1, 1'b1, tk4());
    chk_int("early_stop_no_timeout", n_to, 0);

    // Mode toggled mid-RUN must not move the open valve.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 200 && m_ph != PH_RUN; k++) step(1'b0, 1'b1, 1'b0, tk4());
    for (int k = 0; k < 60 && m_ph == PH_RUN; k++) step(1'b0, 1'b1, 1'b1, tk4());
    for (int k = 0; k < 200 && m_ph != PH_RUN; k++) step(1'b0, 1'b1, 1'b1, tk4());
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("next_run_sprinkler", sprinkler_valve, 1'b1);

    // Reset during RUN, permit held high afterwards.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b1, tk4());

    // Randomized traffic.
    irr_i = 1'b1; md_i = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      r_i = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) irr_i = ~irr_i;
      if ($urandom_range(0, 9) == 0) md_i = ~md_i;
      step(r_i, irr_i, md_i, $urandom_range(0, 2) == 0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
